// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte receiver.
// UART_RX_PARITY_EN adds the PARITY state (even parity after data bit 7).
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY    = 3'd3,
`endif
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Bit period in system clocks; callers must keep the result >= 8.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous level input.
// RESET_VAL selects the value presented while in reset (idle level of the line).
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_byte.sv
// UART receiver: 8 data bits LSB first, mid-bit sampling, one-cycle result pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output; default is 8N1.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rxd,
  output logic [7:0] rx_data,
  output logic      rx_strobe,
  output logic      frame_err,
  output logic      busy,
`ifdef UART_RX_PARITY_EN
  output logic      parity_err,
`endif
  output rx_state_t state_dbg
);

  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rxd_s;
  logic rxd_q;

  rx_state_t state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [2:0]           bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [7:0]           data_nx;
  logic                 strobe_nx;
  logic                 fe_nx;
  logic                 tick;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nx;
  logic                 pe_nx;
`endif

  rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign tick      = (cnt == '0);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    data_nx    = rx_data;
    strobe_nx  = 1'b0;
    fe_nx      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nx     = par_bit;
    pe_nx      = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rxd_q && !rxd_s) begin
          state_nx = START;
          cnt_nx   = HALF_LOAD;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint is treated as a glitch.
        if (tick) begin
          if (!rxd_s) begin
            state_nx   = DATA;
            cnt_nx     = FULL_LOAD;
            bit_idx_nx = '0;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx   = {rxd_s, shreg[DATA_BITS-1:1]};
          cnt_nx     = FULL_LOAD;
          bit_idx_nx = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_nx   = rxd_s;
          cnt_nx   = FULL_LOAD;
          state_nx = STOP;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (tick) begin
          if (rxd_s) begin
            state_nx = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bit != ^shreg) begin
              pe_nx = 1'b1;
            end else begin
              data_nx   = shreg;
              strobe_nx = 1'b1;
            end
`else
            data_nx   = shreg;
            strobe_nx = 1'b1;
`endif
          end else begin
            fe_nx    = 1'b1;
            state_nx = WAIT_HIGH;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line idles so a break is not decoded as 0x00 bytes.
        if (rxd_s) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rxd_q     <= 1'b1;
      rx_data   <= 8'h00;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shreg     <= shreg_nx;
      rxd_q     <= rxd_s;
      rx_data   <= data_nx;
      rx_strobe <= strobe_nx;
      frame_err <= fe_nx;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_nx;
      parity_err <= pe_nx;
    end
  end
`endif

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

UART receiver that deserializes an asynchronous 8-bit serial stream from the MCU into byte-wide data with a one-cycle valid strobe. It sits directly upstream of the byte accumulator/checker stage: rx_data/rx_strobe drive that stage's data_in/data_in_sign. It also reports framing errors and a busy flag for board-level status LEDs.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BAUD, 115200, serial bit rate
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  reset: asynchronous, active-low
- rxd  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last received byte
- rx_strobe  output  1  one-cycle pulse, rx_data newly valid
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  high while a frame is in progress (state != IDLE)
- parity_err  output  1  one-cycle pulse on parity mismatch (present only with UART_RX_PARITY_EN)

## Operation
- CLKS_PER_BIT = CLK_HZ / BAUD (integer division); CLKS_PER_BIT >= 8 is required. Bit counter is $clog2(CLKS_PER_BIT) bits wide and is reloaded, never free-wrapping.
- rxd passes through a 2-flop synchronizer that resets to 1. All decisions use the synchronized value.
- States: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
- IDLE: a synchronized falling edge (1 then 0) -> START, with the counter loaded to CLKS_PER_BIT/2 - 1.
- START: at counter 0, sample. A 0 -> DATA, counter = CLKS_PER_BIT-1, bit index = 0. A 1 is a glitch -> IDLE with no output.
- DATA: sample at each counter expiry and shift LSB first. After bit index 7 -> PARITY if configured, else STOP.
- STOP: sample at expiry.
  - A 1 -> rx_data <= shift register, rx_strobe pulses, -> IDLE.
  - A 0 -> frame_err pulses, rx_data is unchanged, -> WAIT_HIGH.
- WAIT_HIGH: stay until synchronized rxd == 1, then -> IDLE. This prevents a break condition from being decoded as 0x00 frames.
- rx_data holds its value between strobes. rx_strobe, frame_err and parity_err are mutually exclusive.
- Reset mid-frame: all state is discarded immediately. Afterwards the block needs a fresh falling edge, so a frame already in progress is never resumed.

## Timing
- Reset values: rx_data = 8'h00, rx_strobe = 0, frame_err = 0, parity_err = 0, busy = 0, synchronizer = 1, state = IDLE.
- Edge detect latency: 2 clk (synchronizer) + 1 clk (edge register).
- rx_strobe asserts on the clk edge that takes the mid-stop-bit sample: about 9.5 bit times after the line falls (10.5 with parity), plus synchronizer delay. It is high for exactly 1 cycle.
- The return to IDLE happens at mid-stop. A back-to-back start bit that begins immediately after the stop bit must be caught (no dead time).
- busy rises the cycle after the edge is detected and falls in the cycle rx_strobe or frame_err pulses. In the WAIT_HIGH case it falls on exit from WAIT_HIGH.

## Configuration
- UART_RX_PARITY_EN defined:
  - One even-parity bit follows data bit 7 (PARITY state, sampled at counter expiry).
  - On mismatch, parity_err pulses at the stop sample, no rx_strobe is issued, and rx_data is unchanged.
  - A framing error takes priority over a parity error.
- Not defined: 8N1 framing. The PARITY state and the parity_err port are absent.

## Structure
- Package uart_pkg holds:
  - the state enum;
  - a function clks_per_bit(clk_hz, baud);
  - the constant DATA_BITS = 8.
- Sub-module rx_sync: 2-flop synchronizer with parameterized reset value, reusable for other async inputs on the board.

## Test plan
Bench parameters: CLK_HZ = 1_000_000, BAUD = 100_000, so CLKS_PER_BIT = 10.
- Send frame 0x55 -> exactly one rx_strobe with rx_data = 0x55, about 95 clk after the falling edge; frame_err stays 0.
- Send back-to-back 0x01,0x02,0x03,0x04,0x05,0x06,0x07,0x00 with no idle gap -> 8 strobes carrying those values in order; the strobed values sum to 28.
- Drive rxd low for 3 clk, then high -> no strobe, busy returns to 0, and the next frame 0xC3 is received correctly.
- Send 0xA5 with stop bit 0, hold low 50 clk, then high -> one frame_err pulse, no strobe, rx_data unchanged, busy low only after rxd returns high.
- Assert rst_n low after data bit 3 of frame 0xFF, release, then send 0x3C -> all outputs at reset values during reset, one strobe with 0x3C, no spurious byte.
- With UART_RX_PARITY_EN, send 0x03 with parity bit 1 -> parity_err pulse, no strobe. Resend with parity bit 0 -> strobe with rx_data = 0x03.
